// File: rtl/bitperm_pkg.sv
// Shared types and the bit-permutation function for the bitperm pipeline.
// perm() works on a PERM_MAX_W-wide container; only the low `width` bits are meaningful.
package bitperm_pkg;

    typedef enum logic [1:0] {
        PERM_PASS,
        PERM_REVERSE,
        PERM_PAIRSWAP,
        PERM_ROTL
    } perm_mode_e;

    localparam int BEAT_CNT_W = 16;
    localparam int PERM_MAX_W = 64;
    localparam int PERM_IDX_W = $clog2(PERM_MAX_W);

    function automatic logic [PERM_MAX_W-1:0] perm(
        input logic [PERM_MAX_W-1:0] data,
        input perm_mode_e            mode,
        input int                    rot,
        input int                    width
    );
        logic [PERM_MAX_W-1:0] res;
        int                    r;
        int                    src;
        res = '0;
        r   = rot % width;
        for (int i = 0; i < PERM_MAX_W; i++) begin
            src = i;
            case (mode)
                PERM_PASS:     src = i;
                PERM_REVERSE:  src = width - 1 - i;
                // an odd-width MSB has no partner and maps onto itself
                PERM_PAIRSWAP: begin
                    if ((i % 2) == 0) src = ((i + 1) < width) ? i + 1 : i;
                    else              src = i - 1;
                end
                PERM_ROTL:     src = (i + width - r) % width;
                default:       src = i;
            endcase
            if (i < width) res[i] = data[PERM_IDX_W'(src)];
        end
        return res;
    endfunction

endpackage

// File: rtl/bitperm_stage.sv
// One elastic register slice: loads whenever it is empty or downstream takes its beat.
// Data is written only for a valid incoming beat, so an emptied slice keeps its last word.
module bitperm_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid_i,
    input  logic [WIDTH-1:0] up_data_i,
    input  logic             dn_ready_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             load;

    always_comb begin
        load    = !valid_q || dn_ready_i;
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = up_valid_i;
            if (up_valid_i) data_d = up_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign ready_o = load;
    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/bitperm_pipe.sv
// Elastic bit-permutation pipeline: permute on entry, then STAGES register slices.
// Handshake: a beat moves on an edge where valid && ready; ready is a combinational chain back from out_ready.
module bitperm_pipe
    import bitperm_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int ROT_W  = $clog2(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [1:0]            in_mode,
    input  logic [ROT_W-1:0]      in_rot,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [BEAT_CNT_W-1:0] beat_count
);

    logic [WIDTH-1:0]      perm_data;
    logic [STAGES-1:0]     stage_v;
    logic [WIDTH-1:0]      stage_data [STAGES];
    logic [STAGES:0]       stage_ready;
    logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    // WIDTH must not exceed PERM_MAX_W
    always_comb begin
        perm_data = WIDTH'(perm(PERM_MAX_W'(in_data), perm_mode_e'(in_mode),
                                int'(in_rot), WIDTH));
    end

    assign stage_ready[STAGES] = out_ready;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;

        if (i == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = perm_data;
        end else begin : g_body
            assign up_valid = stage_v[i-1];
            assign up_data  = stage_data[i-1];
        end

        bitperm_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .up_valid_i (up_valid),
            .up_data_i  (up_data),
            .dn_ready_i (stage_ready[i+1]),
            .ready_o    (stage_ready[i]),
            .valid_o    (stage_v[i]),
            .data_o     (stage_data[i])
        );
    end

    assign in_ready  = stage_ready[0];
    assign out_valid = stage_v[STAGES-1];
    assign out_data  = stage_data[STAGES-1];

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (out_valid && out_ready) beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) beat_cnt_q <= '0;
        else     beat_cnt_q <= beat_cnt_d;
    end

    assign beat_count = beat_cnt_q;

endmodule

// File: doc/bitperm_pipe.md
# bitperm_pipe

Parametrised, elastic bit-permutation pipeline. It generalises the fixed two-bit registered swap to an arbitrary data width, a selectable permutation mode and a configurable register depth. It has valid/ready flow control and an output beat counter. It sits between a producer and a consumer datapath and is used as a regression vehicle for per-bit netlist splitting across pipeline registers.

## Interface
- WIDTH, 8, data width in bits; must be >= 2.
- STAGES, 2, number of register stages; must be >= 1.
- ROT_W, $clog2(WIDTH), width of the rotate-amount field; derived, not to be overridden.

- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  producer beat present.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  WIDTH  input word.
- in_mode  input  2  permutation mode, sampled with the beat.
- in_rot  input  ROT_W  rotate amount, sampled with the beat.
- out_valid  output  1  output beat present.
- out_ready  input  1  consumer accepts.
- out_data  output  WIDTH  permuted word.
- beat_count  output  16  count of completed output handshakes.

## Operation
- Modes:
  - 0 PASS: out = in.
  - 1 REVERSE: out[i] = in[WIDTH-1-i].
  - 2 PAIRSWAP: out[2k] = in[2k+1] and out[2k+1] = in[2k]. For odd WIDTH, the MSB passes unchanged.
  - 3 ROTL: rotate left by in_rot mod WIDTH.
- The permutation is combinational on the input side and is captured into stage 0. Stages 1..STAGES-1 carry data unchanged.
- Each stage holds a valid bit and a WIDTH data register.
- Stage i loads when !v[i] || ready[i+1]. ready[STAGES] = out_ready.
- in_ready = !v[0] || ready[1]. This is a combinational ready chain; there is no skid buffer.
- Input handshake: in_valid && in_ready. Output handshake: out_valid && out_ready.
- out_valid = v[STAGES-1] and out_data = stage STAGES-1 data.
- Data order is preserved. No beat is dropped or duplicated under any out_ready pattern.
- beat_count increments by 1 per output handshake and wraps 16'hFFFF -> 0.
- A stage keeps its data while stalled. out_data is stable while out_valid && !out_ready.
- When a stage holds no beat, its data register is not updated.

## Timing
- Reset (asynchronous assert, synchronous release by clock edge):
  - all v[i] = 0, all data = 0, beat_count = 0.
  - out_valid = 0, out_data = 0.
  - in_ready = 1 from the first cycle after reset.
- Latency with no stall: a beat accepted at edge n appears on out_valid/out_data after edge n+STAGES-1. STAGES=1 gives a registered output one edge after acceptance.
- Throughput: 1 beat/cycle while out_ready = 1.
- Full pipeline (all v = 1) with out_ready = 0: in_ready = 0.
- Full pipeline with out_ready = 1: in_ready = 1. Simultaneous accept and emit keeps occupancy at STAGES.
- in_mode and in_rot matter only on the accepting cycle. A change between beats affects only later beats.
- Reset mid-operation: in-flight beats are discarded and beat_count is cleared immediately on rst assertion. No output beat is produced from pre-reset data.

## Structure
- Package bitperm_pkg holds:
  - typedef enum logic [1:0] {PERM_PASS, PERM_REVERSE, PERM_PAIRSWAP, PERM_ROTL} perm_mode_e;
  - the beat-count width constant BEAT_CNT_W = 16.
- Sub-module bitperm_stage is one elastic register slice (valid, data, load enable, ready out), parametrised by WIDTH and instantiated STAGES times through a generate loop.
- The permutation function is a package function perm(data, mode, rot), so that the bench reuses it as its reference model.

## Test plan
- Reset: assert rst for 3 cycles with in_valid = 1 -> out_valid = 0, out_data = 0, beat_count = 0 throughout; in_ready = 1 on the first cycle after release.
- PAIRSWAP, WIDTH=8, STAGES=2: 8'b1011_0010 -> 8'b0111_0001 on the cycle after the next edge; beat_count = 1 after the handshake.
- REVERSE 8'h01 -> 8'h80; ROTL rot=1 on 8'h81 -> 8'h03; PASS 8'h5A -> 8'h5A. Sent back-to-back, they emerge in order on consecutive cycles.
- Backpressure, STAGES=2: hold out_ready = 0 and offer beats A, B, C. A and B are accepted, in_ready = 0 while C is offered, and out_data = A is stable. Release out_ready -> A, B, C are emitted in order with no gap, and beat_count = 3.
- WIDTH=5:
  - PAIRSWAP 5'b10110 -> 5'b11001 (MSB unchanged).
  - ROTL rot=6 on 5'b00001 -> 5'b00010 (rotate amount taken mod 5).
- Reset mid-stream: with two beats in flight, pulse rst between edges -> outputs clear immediately, the discarded beats never appear, and beat_count = 0. Random stimulus then matches the perm() model for 1000 beats with a random out_ready pattern.
